hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Iterative multi-cycle multiply/divide engine for the EX stage, producing the 64-bit HI/LO results for mult, multu, div and divu. It takes operands from the ID/EX pipeline register outputs and writes its results into the HI/LO registers. While an operation is in flight it asserts a stall that freezes the PC, IF/ID and ID/EX. One operation runs at a time, with a fixed latency of 34 cycles from Start to Done.

## Interface
- WIDTH, 32: operand width; Hi/Lo are each WIDTH bits
- Clk  in  1  clock; all state changes on the rising edge
- Rst  in  1  synchronous, active-low reset: sampled on the Clk rising edge, takes effect when 0
- Start  in  1  request a new operation; accepted only in IDLE
- Op  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu; sampled with Start
- A  in  WIDTH  rs operand (multiplicand / dividend); sampled with Start
- B  in  WIDTH  rt operand (multiplier / divisor); sampled with Start
- Busy  out  1  high in RUN, FIXUP and DONE
- Stall  out  1  combinational: (state==IDLE & Start) | state==RUN | state==FIXUP
- Done  out  1  one-cycle pulse; Hi, Lo and DivByZero are valid while it is high
- Hi  out  WIDTH  product[63:32] or remainder
- Lo  out  WIDTH  product[31:0] or quotient
- DivByZero  out  1  set with Done when a div/divu had B==0; held until the next Done

## Operation
- FSM states: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - Start=1 latches Op, A and B and takes the magnitudes |A| and |B| (signed ops only), records the result-sign flags, clears the 6-bit iteration counter, then goes to RUN.
  - Start=0: stay in IDLE.
- RUN: one iteration per cycle, counter increments. After the 32nd iteration (counter == 31 at the edge), go to FIXUP.
  - Multiply: radix-2 shift-add on the magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract on the magnitudes, giving remainder and quotient.
- FIXUP: apply two's-complement sign correction, register Hi, Lo and DivByZero, then go to DONE.
  - mult: negate the 64-bit product if sign(A) xor sign(B).
  - div: negate the quotient if sign(A) xor sign(B); the remainder takes the sign of A.
  - Quotient truncates toward zero.
- DONE: Done=1 for exactly one cycle, then unconditionally return to IDLE.
- Start while Busy is ignored; a new Start is accepted only when the FSM is back in IDLE.
- Divide by zero (B==0, div or divu):
  - Runs the full latency.
  - Result: Hi=A (original, unmodified), Lo=all ones, DivByZero=1.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No flag is raised.
- Hi and Lo hold their last result until the next FIXUP; they are not cleared on Start.
- Arithmetic is unsigned internally on WIDTH-bit magnitudes with a 2*WIDTH accumulator. Carries beyond 2*WIDTH are discarded.

## Timing
- Reset values: state=IDLE, Busy=0, Stall=0 (provided Start=0), Done=0, Hi=0, Lo=0, DivByZero=0, counter=0.
- Start sampled at edge E0 → RUN during cycles E0..E32 → FIXUP during E32..E33 → DONE during E33..E34 → IDLE after E34.
- Done is high in the cycle between E33 and E34; Busy is high from E0 through E34.
- Stall is high from Start (same cycle, combinational) until E33. It is low during the Done cycle, so the stalled instruction advances and the downstream HI/LO write uses Hi/Lo in the Done cycle.
- Rst=0 at any edge, including mid-RUN, forces every output and register to its reset value at that edge. The operation is abandoned and no Done is issued.
- Rst=0 together with Start=1: reset wins and the operation is not accepted.
- Back-to-back operations: the earliest next Start acceptance is at E34 (first IDLE cycle), so the minimum spacing is 34 cycles.

## Test plan
- mult A=0xFFFFFFFD (-3), B=7 → Done exactly 34 cycles after the Start edge; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, DivByZero=0.
- multu A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001. mult with the same operands → Hi=0, Lo=1.
- div A=0xFFFFFFF9 (-7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - Then div 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- divu A=100, B=0 → Done at 34 cycles with DivByZero=1, Hi=0x00000064, Lo=0xFFFFFFFF.
  - A following multu 3×4 → DivByZero=0, Lo=12, Hi=0.
- Start pulsed again at cycles 5 and 33 of a running mult → ignored. Exactly one Done at cycle 34, operands from the first Start. Stall is low in the Done cycle.
- Rst=0 for one edge at RUN iteration 10 → next cycle Busy=0, Stall=0, Hi=Lo=0, no Done within 40 cycles. A fresh Start then completes normally.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-cycle multiply/divide engine producing HI/LO for mult, multu, div and divu.
// Shift-add multiply and restoring divide share one accumulator pair; sign fixup runs after the loop.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t           state_reg;
    logic [5:0]       count_reg;
    logic             is_div_reg;
    logic             neg_res_reg;
    logic             neg_rem_reg;
    logic             b_zero_reg;
    logic [WIDTH-1:0] a_orig_reg;
    logic [WIDTH-1:0] b_mag_reg;
    logic [WIDTH-1:0] acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;

    logic             signed_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;

    assign signed_op = ~Op[0];
    assign a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
    assign b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;

    // Multiply: acc_lo holds the multiplier and is shifted out LSB-first while
    // the partial sum (with its carry) shifts in from the top.
    assign add_sum   = {1'b0, acc_hi_reg} + {1'b0, (acc_lo_reg[0] ? b_mag_reg : {WIDTH{1'b0}})};

    // Divide: acc_hi is the partial remainder, acc_lo the dividend turning into the quotient.
    assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_mag_reg};

    assign prod_raw  = {acc_hi_reg, acc_lo_reg};
    assign prod_fix  = neg_res_reg ? -prod_raw : prod_raw;

    assign Busy  = (state_reg != IDLE);
    assign Done  = (state_reg == DONE);
    assign Stall = ((state_reg == IDLE) && Start) || (state_reg == RUN) || (state_reg == FIXUP);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            b_zero_reg  <= 1'b0;
            a_orig_reg  <= '0;
            b_mag_reg   <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            Hi          <= '0;
            Lo          <= '0;
            DivByZero   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        is_div_reg  <= Op[1];
                        neg_res_reg <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem_reg <= signed_op && A[WIDTH-1];
                        b_zero_reg  <= (B == '0);
                        a_orig_reg  <= A;
                        b_mag_reg   <= b_mag;
                        acc_hi_reg  <= '0;
                        acc_lo_reg  <= a_mag;
                        count_reg   <= '0;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (is_div_reg) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi_reg <= div_diff[WIDTH-1:0];
                            acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_reg <= div_shift[WIDTH-1:0];
                            acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_reg <= add_sum[WIDTH:1];
                        acc_lo_reg <= {add_sum[0], acc_lo_reg[WIDTH-1:1]};
                    end
                    count_reg <= count_reg + 6'd1;
                    if (count_reg == 6'd31)
                        state_reg <= FIXUP;
                end
                FIXUP: begin
                    if (is_div_reg && b_zero_reg) begin
                        Hi        <= a_orig_reg;
                        Lo        <= '1;
                        DivByZero <= 1'b1;
                    end else if (is_div_reg) begin
                        Hi        <= neg_rem_reg ? -acc_hi_reg : acc_hi_reg;
                        Lo        <= neg_res_reg ? -acc_lo_reg : acc_lo_reg;
                        DivByZero <= 1'b0;
                    end else begin
                        Hi        <= prod_fix[2*WIDTH-1:WIDTH];
                        Lo        <= prod_fix[WIDTH-1:0];
                        DivByZero <= 1'b0;
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: the driver queues expected HI/LO from plain
// 64-bit arithmetic, and a negedge monitor compares whenever Done is presented.
module tb_hilo_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        DivByZero;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Stall(Stall), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // Reference: ISA semantics via 64-bit integer arithmetic (division truncates toward zero).
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb_, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        e.op = op; e.a = a; e.b = b; e.dbz = 1'b0; e.due = 0;
        case (op)
            2'b00: begin p = sa * sb_; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    q = sa / sb_; r = sa % sb_;
                    e.hi = r[31:0]; e.lo = q[31:0];
                end else begin
                    e.hi = 32'(ua % ub); e.lo = 32'(ua / ub);
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dbz=%0b (exp hi=%08h lo=%08h dbz=%0b) cyc=%0d",
                         e.op, e.a, e.b, Hi, Lo, DivByZero, e.hi, e.lo, e.dbz, cyc);
                check("hi", {32'b0, Hi}, {32'b0, e.hi});
                check("lo", {32'b0, Lo}, {32'b0, e.lo});
                check("divbyzero", {63'b0, DivByZero}, {63'b0, e.dbz});
                check("latency", 64'(cyc), 64'(e.due));
                check("stall_in_done", {63'b0, Stall}, 64'd0);
                check("busy_in_done", {63'b0, Busy}, 64'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 50) begin @(negedge Clk); n++; end
        if (Busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    // Drive Start for one edge; the expectation is queued only if the op should complete.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        exp_t e;
        wait_idle();
        Op = op; A = a; B = b; Start = 1'b1;
        if (expect_done) begin
            e = model(op, a, b);
            e.due = cyc + 34;
            sb.push_back(e);
        end
        #1;
        check("stall_on_start", {63'b0, Stall}, 64'd1);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!Done && n < 40) begin @(negedge Clk); n++; end
        if (!Done) check("done_timeout", 64'd0, 64'd1);
        @(negedge Clk);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b, 1'b1);
        wait_done();
    endtask

    initial begin
        Rst = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", {63'b0, Busy}, 64'd0);
        check("rst_stall", {63'b0, Stall}, 64'd0);
        check("rst_done", {63'b0, Done}, 64'd0);
        check("rst_hilo", {Hi, Lo}, 64'd0);
        check("rst_dbz", {63'b0, DivByZero}, 64'd0);
        Rst = 1'b1;
        @(negedge Clk);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd100, 32'd0);
        run_op(2'b01, 32'd3, 32'd4);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE);

        // Extra Start pulses at E5 and E33 of a running mult must be ignored.
        issue(2'b00, 32'h1234_5678, 32'hFFFF_F00F, 1'b1);
        repeat (4) @(negedge Clk);
        Op = 2'b11; A = 32'd99; B = 32'd5; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (27) @(negedge Clk);
        check("stall_in_fixup", {63'b0, Stall}, 64'd1);
        Op = 2'b01; A = 32'd11; B = 32'd13; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done();

        // Reset at RUN iteration 10 abandons the operation.
        issue(2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        repeat (9) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        check("midrun_rst_busy", {63'b0, Busy}, 64'd0);
        check("midrun_rst_stall", {63'b0, Stall}, 64'd0);
        check("midrun_rst_hilo", {Hi, Lo}, 64'd0);
        check("midrun_rst_dbz", {63'b0, DivByZero}, 64'd0);
        begin
            int dn = 0;
            repeat (40) begin @(negedge Clk); if (Done) dn++; end
            check("no_done_after_rst", 64'(dn), 64'd0);
        end

        // Reset together with Start: reset wins.
        Rst = 1'b0; Start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd6;
        @(negedge Clk);
        Rst = 1'b1; Start = 1'b0;
        check("rst_start_busy", {63'b0, Busy}, 64'd0);

        run_op(2'b00, 32'd6, 32'hFFFF_FFF9);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(op, a, b);
        end

        repeat (3) @(negedge Clk);
        check("pending_results", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
